// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: pipelined ALU functional unit with elastic, bubble-collapsing slots.
// Optional build macro FU_ALU_SAT_EN: opcodes 0xA/0xB become signed saturating ADDS/SUBS.
module fu_alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_aluop,
    input  logic [WIDTH-1:0] in_port_a,
    input  logic [WIDTH-1:0] in_port_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_port_output,
    output logic             out_negative,
    output logic             out_overflow,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int SH = $clog2(WIDTH);
    localparam int DW = WIDTH + 3 + TAG_W;

    logic [WIDTH-1:0] sum, dif, res, lim;
    logic [SH-1:0]    amt;
    logic             ovf, ovf_add, ovf_sub;
    logic [DW-1:0]    slot_in;
    logic [STAGES:0]  adv;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [DW-1:0]    data_q [STAGES];
    logic [DW-1:0]    data_d [STAGES];

    assign sum     = in_port_a + in_port_b;
    assign dif     = in_port_a - in_port_b;
    assign amt     = in_port_b[SH-1:0];
    assign ovf_add = (in_port_a[WIDTH-1] == in_port_b[WIDTH-1]) & (sum[WIDTH-1] != in_port_a[WIDTH-1]);
    assign ovf_sub = (in_port_a[WIDTH-1] != in_port_b[WIDTH-1]) & (dif[WIDTH-1] != in_port_a[WIDTH-1]);
    // A signed overflow always goes in the direction of operand A's sign, so A picks the clamp value.
    assign lim     = {in_port_a[WIDTH-1], {(WIDTH-1){~in_port_a[WIDTH-1]}}};
    assign slot_in = {res, res[WIDTH-1], ovf, res == '0, in_tag};

    // Stage-0 datapath: result and overflow for the presented op.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (in_aluop)
            4'h0: begin res = sum; ovf = ovf_add; end
            4'h1: begin res = dif; ovf = ovf_sub; end
            4'h2: res = in_port_a & in_port_b;
            4'h3: res = in_port_a | in_port_b;
            4'h4: res = in_port_a ^ in_port_b;
            4'h5: res = in_port_a << amt;
            4'h6: res = in_port_a >> amt;
            4'h7: res = $unsigned($signed(in_port_a) >>> amt);
            4'h8: res = WIDTH'($signed(in_port_a) < $signed(in_port_b));
            4'h9: res = WIDTH'(in_port_a < in_port_b);
`ifdef FU_ALU_SAT_EN
            4'hA: begin res = ovf_add ? lim : sum; ovf = ovf_add; end
            4'hB: begin res = ovf_sub ? lim : dif; ovf = ovf_sub; end
`endif
            default: res = '0;
        endcase
    end

    // Slot advance chain from the output back, then next-state of every slot.
    always_comb begin
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) adv[k] = !valid_q[k] | adv[k+1];
        in_ready   = adv[0] & !flush & !RST;
        valid_d[0] = flush ? 1'b0 : adv[0] ? in_valid & in_ready : valid_q[0];
        data_d[0]  = adv[0] ? slot_in : data_q[0];
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = flush ? 1'b0 : adv[k] ? valid_q[k-1] : valid_q[k];
            data_d[k]  = adv[k] ? data_q[k-1] : data_q[k];
        end
    end

    // Slot registers with synchronous reset of valid and payload.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[STAGES-1] & !RST;
    assign {out_port_output, out_negative, out_overflow, out_zero, out_tag} = data_q[STAGES-1];
endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb_fu_alu_pipe: scoreboard bench for fu_alu_pipe against an arithmetic reference model.
module tb_fu_alu_pipe;
    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 5;

    logic          CLK = 1'b0, RST = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0]    in_aluop = '0;
    logic [W-1:0]  a = '0, b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_ready, out_valid, out_negative, out_overflow, out_zero;
    logic [W-1:0]  out_port_output;
    logic [TW-1:0] out_tag;

    fu_alu_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_aluop(in_aluop), .in_port_a(a), .in_port_b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_port_output(out_port_output),
        .out_negative(out_negative), .out_overflow(out_overflow), .out_zero(out_zero),
        .out_tag(out_tag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0]  r;
        logic          n, v, z;
        logic [TW-1:0] t;
        int            ac;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, fails = 0, cyc = 0, last_low = -1;
    logic hold_pend = 1'b0;
    logic [W+3+TW-1:0] held;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: signed sums in 64 bits, overflow when outside the W-bit signed range.
    function automatic exp_t model(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y, logic [TW-1:0] t, int ac);
        exp_t e;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint wide = 0;
        int amt = int'(y[4:0]);
        e.r = '0;
        e.v = 1'b0;
        if (op == 4'h0 || op == 4'h1 || op == 4'hA || op == 4'hB) begin
            wide = op[0] ? sx - sy : sx + sy;
            e.v  = (wide > 64'sh7FFFFFFF) || (wide < -64'sh80000000);
            e.r  = wide[31:0];
            if (op >= 4'hA) begin
`ifdef FU_ALU_SAT_EN
                if (e.v) e.r = (wide > 0) ? 32'h7FFFFFFF : 32'h80000000;
`else
                e.r = '0;
                e.v = 1'b0;
`endif
            end
        end else begin
            case (op)
                4'h2: e.r = x & y;
                4'h3: e.r = x | y;
                4'h4: e.r = x ^ y;
                4'h5: e.r = x << amt;
                4'h6: e.r = x >> amt;
                4'h7: begin wide = sx >>> amt; e.r = wide[31:0]; end
                4'h8: e.r = (sx < sy) ? 1 : 0;
                4'h9: e.r = (x < y) ? 1 : 0;
                default: e.r = '0;
            endcase
        end
        e.n  = e.r[W-1];
        e.z  = (e.r == 0);
        e.t  = t;
        e.ac = ac;
        return e;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: checks held outputs, pops on output handshakes, pushes on input handshakes.
    always @(negedge CLK) begin
        exp_t e;
        if (hold_pend) chk("hold_stable", {out_port_output, out_negative, out_overflow, out_zero, out_tag}, held);
        hold_pend = 1'b0;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) chk("unexpected_output", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("result", out_port_output, e.r);
                chk("flags_nvz", {out_negative, out_overflow, out_zero}, {e.n, e.v, e.z});
                chk("tag", out_tag, e.t);
                if (e.ac > last_low) chk("latency", cyc - e.ac, S);
            end
        end
        if (out_valid && !out_ready && !flush && !RST) begin
            hold_pend = 1'b1;
            held = {out_port_output, out_negative, out_overflow, out_zero, out_tag};
        end
        if (!out_ready) last_low = cyc;
        if (in_valid && in_ready) sbq.push_back(model(in_aluop, a, b, in_tag, cyc));
    end

    task automatic issue(logic [3:0] op, logic [W-1:0] x, logic [W-1:0] y, logic [TW-1:0] t, output int tries);
        logic ok = 1'b0;
        in_valid = 1'b1; in_aluop = op; a = x; b = y; in_tag = t;
        tries = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            tries++;
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("issue_timeout", 0, 1);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge CLK);
        chk("drain_empty", sbq.size(), 0);
        @(posedge CLK); #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(5))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int tr, acc;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outputs", {out_port_output, out_negative, out_overflow, out_zero, out_tag}, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        issue(4'h0, 3, 4, 1, tr);
        chk("accept_after_reset", tr, 1);
        issue(4'h1, 3, 4, 2, tr);
        issue(4'h0, 32'h7FFFFFFF, 1, 3, tr);
        issue(4'h1, 5, 5, 4, tr);
        issue(4'h7, 32'h80000000, 32'h21, 5, tr);
        issue(4'h9, 1, 32'hFFFFFFFF, 6, tr);
        issue(4'h8, 1, 32'hFFFFFFFF, 7, tr);
        issue(4'hA, 32'h7FFFFFFF, 5, 8, tr);
        issue(4'hB, 32'h80000000, 1, 9, tr);
        issue(4'hE, 32'h12345678, 3, 10, tr);
        drain();
        // Backpressure: only S ops fit while the consumer stalls.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1; in_aluop = 4'h0; a = pick(); b = pick(); in_tag = 11;
        repeat (6) begin
            @(negedge CLK);
            tr = in_ready;
            if (tr != 0) acc++;
            @(posedge CLK); #1;
            if (tr != 0) begin in_aluop = 4'($urandom_range(9)); a = pick(); b = pick(); in_tag = in_tag + 1; end
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc, S);
        out_ready = 1'b1;
        drain();
        // Flush with two ops in flight.
        issue(4'h3, 32'hF0, 32'h0F, 20, tr);
        issue(4'h4, 32'hFF, 32'h0F, 21, tr);
        flush = 1'b1; in_valid = 1'b1; in_aluop = 4'h0; in_tag = 22;
        @(negedge CLK);
        chk("flush_in_ready", in_ready, 0);
        @(posedge CLK); #1;
        flush = 1'b0; in_valid = 1'b0;
        sbq.delete();
        @(negedge CLK);
        chk("flush_out_valid", out_valid, 0);
        @(posedge CLK); #1;
        // Reset mid-stream.
        issue(4'h5, 32'h1, 32'h4, 23, tr);
        issue(4'h6, 32'h80, 32'h3, 24, tr);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge CLK); #1;
        sbq.delete();
        @(negedge CLK);
        chk("midrst_outputs", {out_valid, out_port_output, out_negative, out_overflow, out_zero, out_tag}, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        issue(4'h2, 32'hFF00FF00, 32'h0FF00FF0, 25, tr);
        chk("accept_after_midrst", tr, 1);
        drain();
        // Random traffic with random backpressure.
        repeat (600) begin
            out_ready = ($urandom_range(3) != 0);
            in_valid  = ($urandom_range(3) != 0);
            in_aluop  = 4'($urandom_range(15));
            a = pick(); b = pick(); in_tag = 5'($urandom);
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
